// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics write path.
//   - Host register indices decoded by vram_write_ctrl.
//   - Display mode encoding and the XY/linear classification helper.
//   - Default screen geometry.
//   - Clear/fill engine state type.
package gfx_pkg;

  localparam logic [3:0] REG_DATA = 4'd1;
  localparam logic [3:0] REG_CURX = 4'd3;
  localparam logic [3:0] REG_CURY = 4'd4;
  localparam logic [3:0] REG_FILL = 4'd5;
  localparam logic [3:0] REG_CLR  = 4'd7;

  localparam logic [1:0] MODE_XY0  = 2'd0;
  localparam logic [1:0] MODE_XY1  = 2'd1;
  localparam logic [1:0] MODE_LIN0 = 2'd2;
  localparam logic [1:0] MODE_LIN1 = 2'd3;

  localparam int TXT_COLS_DEF  = 80;
  localparam int TXT_ROWS_DEF  = 60;
  localparam int LIN_WORDS_DEF = 38400;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL_WAIT = 2'd1,
    ST_FILL      = 2'd2,
    ST_DONE      = 2'd3
  } fill_state_t;

  // Modes 2 and 3 use a flat byte address; 0 and 1 use {row, column}.
  function automatic logic is_linear(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  write side; a push while full is ignored
//   pop, rdata   read side; rdata shows the head entry, pop advances it
//   count        number of stored entries (0..DEPTH)
//   full, empty  count == DEPTH / count == 0
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_ctrl.sv
// Turns host register writes into screen-RAM writes.
// Holds an auto-incrementing cursor (XY text or linear bitmap addressing),
// queues data writes in a FIFO drained one per cycle, and optionally sweeps
// the whole screen with a fill byte.
// Build option: define VRAM_FILL_EN to include the clear/fill engine;
// without it register 5 is ignored and busy only reflects the FIFO.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mode                  0/1 XY addressing, 2/3 linear
//   host_we/rs/data       one-cycle register write
//   ram_wraddr/data/wren  registered screen-RAM write port
//   busy                  FIFO non-empty or fill in progress
//   fifo_full, overflow   FIFO full; sticky dropped-push flag (cleared by reg 7)
//   cursor_x, cursor_y    cursor column/row (linear: address low/high byte)
module vram_write_ctrl
  import gfx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TXT_COLS   = TXT_COLS_DEF,
  parameter int TXT_ROWS   = TXT_ROWS_DEF,
  parameter int LIN_WORDS  = LIN_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              host_we,
  input  logic [3:0]        host_rs,
  input  logic [DATA_W-1:0] host_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow,
  output logic [7:0]        cursor_x,
  output logic [7:0]        cursor_y
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  COL_LAST = 8'(TXT_COLS - 1);
  localparam logic [7:0]  ROW_LAST = 8'(TXT_ROWS - 1);
  localparam logic [15:0] LIN_LAST = 16'(LIN_WORDS - 1);

  // Out-of-range coordinates are kept until the next advance, where the
  // >= compares fold them back to zero.
  function automatic logic [15:0] xy_advance(input logic [15:0] a);
    logic [7:0] x;
    logic [7:0] y;
    x = a[7:0];
    y = a[15:8];
    if (x >= COL_LAST) begin
      x = 8'd0;
      y = (y >= ROW_LAST) ? 8'd0 : y + 8'd1;
    end else begin
      x = x + 8'd1;
    end
    return {y, x};
  endfunction

  function automatic logic [15:0] lin_advance(input logic [15:0] a);
    return (a >= LIN_LAST) ? 16'd0 : a + 16'd1;
  endfunction

  logic [7:0]        cur_x;
  logic [7:0]        cur_y;
  logic [15:0]       cur_addr;
  logic [1:0]        mode_q;
  logic              wr_data;
  logic              wr_curx;
  logic              wr_cury;
  logic              wr_clr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full_w;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_rdata;
  logic              fill_done;
  logic              overflow_q;
  logic              vld_p1;
  logic [ADDR_W-1:0] wraddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  assign cur_addr   = {cur_y, cur_x};
  assign wr_data    = host_we && (host_rs == REG_DATA);
  assign wr_curx    = host_we && (host_rs == REG_CURX);
  assign wr_cury    = host_we && (host_rs == REG_CURY);
  assign wr_clr     = host_we && (host_rs == REG_CLR);
  // The push captures the cursor as it stands before this edge's update.
  assign fifo_push  = wr_data && !fifo_full_w;
  assign fifo_wdata = {ADDR_W'(cur_addr), host_data};

  sync_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  // Cursor: a mode change or the end of a fill wins over register writes.
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (rst) begin
      cur_x <= 8'd0;
      cur_y <= 8'd0;
    end else if ((mode != mode_q) || fill_done) begin
      cur_x <= 8'd0;
      cur_y <= 8'd0;
    end else if (wr_curx) begin
      cur_x <= 8'(host_data);
    end else if (wr_cury) begin
      cur_y <= 8'(host_data);
    end else if (wr_data) begin
      {cur_y, cur_x} <= is_linear(mode) ? lin_advance(cur_addr) : xy_advance(cur_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        overflow_q <= 1'b0;
    else if (wr_data && fifo_full_w) overflow_q <= 1'b1;
    else if (wr_clr)                overflow_q <= 1'b0;
  end

`ifdef VRAM_FILL_EN
  fill_state_t       state;
  fill_state_t       state_nx;
  logic              wr_fill;
  logic              fill_wr;
  logic              fill_last;
  logic              fill_lin;
  logic [15:0]       fill_addr;
  logic [DATA_W-1:0] fill_byte;

  assign wr_fill   = host_we && (host_rs == REG_FILL);
  assign fill_done = (state == ST_DONE);
  assign fill_last = fill_lin ? (fill_addr == LIN_LAST)
                              : (fill_addr == {ROW_LAST, COL_LAST});
  assign busy      = (fifo_cnt != '0) || (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Entries queued before the fill command are still drained while waiting,
  // so host write order is kept; once sweeping, new pushes wait for DONE.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    fill_wr  = 1'b0;
    case (state)
      ST_IDLE: begin
        fifo_pop = !fifo_empty;
        if (wr_fill) state_nx = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        fifo_pop = !fifo_empty;
        if (fifo_empty) state_nx = ST_FILL;
      end
      ST_FILL: begin
        fill_wr = 1'b1;
        if (fill_last) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Mode class is latched at the command so a later mode change cannot
  // alter the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_lin  <= 1'b0;
      fill_addr <= 16'd0;
    end else if ((state == ST_IDLE) && wr_fill) begin
      fill_lin  <= is_linear(mode);
      fill_addr <= 16'd0;
    end else if (fill_wr) begin
      fill_addr <= fill_lin ? lin_advance(fill_addr) : xy_advance(fill_addr);
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && wr_fill) fill_byte <= host_data;
  end
`else
  assign fill_done = 1'b0;
  assign fifo_pop  = !fifo_empty;
  assign busy      = (fifo_cnt != '0);
`endif

  // Stage p1: registered RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      wraddr_p1 <= '0;
      wdata_p1  <= '0;
    end else if (fifo_pop) begin
      vld_p1    <= 1'b1;
      wraddr_p1 <= fifo_rdata[ENT_W-1:DATA_W];
      wdata_p1  <= fifo_rdata[DATA_W-1:0];
`ifdef VRAM_FILL_EN
    end else if (fill_wr) begin
      vld_p1    <= 1'b1;
      wraddr_p1 <= ADDR_W'(fill_addr);
      wdata_p1  <= fill_byte;
`endif
    end else begin
      vld_p1    <= 1'b0;
    end
  end

  assign ram_wren   = vld_p1;
  assign ram_wraddr = wraddr_p1;
  assign ram_data   = wdata_p1;
  assign fifo_full  = fifo_full_w;
  assign overflow   = overflow_q;
  assign cursor_x   = cur_x;
  assign cursor_y   = cur_y;

endmodule

// File: tb/tb_vram_write_ctrl.sv
module tb_vram_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        host_we = 1'b0;
  logic [3:0]  host_rs = 4'd0;
  logic [7:0]  host_data = 8'd0;
  logic [15:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  cursor_x;
  logic [7:0]  cursor_y;

  int errors = 0;
  int checks = 0;

  vram_write_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .host_we    (host_we),
    .host_rs    (host_rs),
    .host_data  (host_data),
    .ram_wraddr (ram_wraddr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [3:0] rs, input logic [7:0] d);
    host_we = 1'b1; host_rs = rs; host_data = d;
    tick();
    host_we = 1'b0; host_rs = 4'd0; host_data = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== 25'd0) begin errors++;
      $display("FAIL reset_ram: got wren=%0b addr=%h data=%h want all 0", ram_wren, ram_wraddr, ram_data); end
    checks++; if ({busy, fifo_full, overflow} !== 3'b000) begin errors++;
      $display("FAIL reset_status: got busy=%0b full=%0b ovf=%0b want 000", busy, fifo_full, overflow); end
    rst = 1'b0;
    tick();
    checks++; if ({cursor_y, cursor_x, ram_wren} !== 17'd0) begin errors++;
      $display("FAIL reset_cursor: got y=%h x=%h wren=%0b want 0", cursor_y, cursor_x, ram_wren); end
  endtask

  task automatic test_xy_push();
    host_wr(4'd3, 8'd78);
    host_wr(4'd4, 8'd5);
    checks++; if ({cursor_y, cursor_x} !== 16'h054E) begin errors++;
      $display("FAIL xy_cur_set: got %h want 054e", {cursor_y, cursor_x}); end
    host_we = 1'b1; host_rs = 4'd1;
    host_data = 8'h41; tick();
    checks++; if (ram_wren !== 1'b0) begin errors++;
      $display("FAIL xy_latency: wren got %0b want 0 on push edge", ram_wren); end
    host_data = 8'h42; tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h054E, 8'h41}) begin errors++;
      $display("FAIL xy_w0: got wren=%0b addr=%h data=%h want 1 054e 41", ram_wren, ram_wraddr, ram_data); end
    host_data = 8'h43; tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h054F, 8'h42}) begin errors++;
      $display("FAIL xy_w1: got wren=%0b addr=%h data=%h want 1 054f 42", ram_wren, ram_wraddr, ram_data); end
    host_we = 1'b0; host_rs = 4'd0; host_data = 8'd0;
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h0600, 8'h43}) begin errors++;
      $display("FAIL xy_w2: got wren=%0b addr=%h data=%h want 1 0600 43", ram_wren, ram_wraddr, ram_data); end
    tick();
    checks++; if ({ram_wren, busy} !== 2'b00) begin errors++;
      $display("FAIL xy_idle: got wren=%0b busy=%0b want 0 0", ram_wren, busy); end
    checks++; if ({cursor_y, cursor_x} !== 16'h0601) begin errors++;
      $display("FAIL xy_cur_end: got %h want 0601", {cursor_y, cursor_x}); end
  endtask

  task automatic test_linear();
    mode = 2'd2;
    tick(); tick();
    checks++; if ({cursor_y, cursor_x} !== 16'h0000) begin errors++;
      $display("FAIL mode_cur_reset: got %h want 0000", {cursor_y, cursor_x}); end
    host_wr(4'd4, 8'h95);
    host_wr(4'd3, 8'hFF);
    host_we = 1'b1; host_rs = 4'd1;
    host_data = 8'hAA; tick();
    host_data = 8'hBB; tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'd38399, 8'hAA}) begin errors++;
      $display("FAIL lin_w0: got wren=%0b addr=%0d data=%h want 1 38399 aa", ram_wren, ram_wraddr, ram_data); end
    host_we = 1'b0; host_rs = 4'd0; host_data = 8'd0;
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'd0, 8'hBB}) begin errors++;
      $display("FAIL lin_w1: got wren=%0b addr=%0d data=%h want 1 0 bb", ram_wren, ram_wraddr, ram_data); end
    checks++; if ({cursor_y, cursor_x} !== 16'd1) begin errors++;
      $display("FAIL lin_cur_end: got %0d want 1", {cursor_y, cursor_x}); end
  endtask

  task automatic test_push_with_mode_change();
    mode = 2'd0;
    host_wr(4'd1, 8'h55);
    checks++; if ({cursor_y, cursor_x} !== 16'd0) begin errors++;
      $display("FAIL modechg_cur: got %h want 0000", {cursor_y, cursor_x}); end
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h0001, 8'h55}) begin errors++;
      $display("FAIL modechg_w: got wren=%0b addr=%h data=%h want 1 0001 55", ram_wren, ram_wraddr, ram_data); end
  endtask

  task automatic test_xy_wrap();
    host_wr(4'd3, 8'd79);
    host_wr(4'd4, 8'd59);
    host_wr(4'd1, 8'h61);
    checks++; if ({cursor_y, cursor_x} !== 16'h0000) begin errors++;
      $display("FAIL wrap_cur: got %h want 0000", {cursor_y, cursor_x}); end
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h3B4F, 8'h61}) begin errors++;
      $display("FAIL wrap_w: got wren=%0b addr=%h data=%h want 1 3b4f 61", ram_wren, ram_wraddr, ram_data); end
    host_wr(4'd3, 8'd200);
    host_wr(4'd4, 8'd100);
    host_wr(4'd1, 8'h62);
    checks++; if ({cursor_y, cursor_x} !== 16'h0000) begin errors++;
      $display("FAIL oor_cur: got %h want 0000", {cursor_y, cursor_x}); end
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h64C8, 8'h62}) begin errors++;
      $display("FAIL oor_w: got wren=%0b addr=%h data=%h want 1 64c8 62", ram_wren, ram_wraddr, ram_data); end
  endtask

  task automatic test_ignored_regs();
    logic [3:0] ign [5] = '{4'd0, 4'd2, 4'd6, 4'd8, 4'd15};
    bit seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_wr(ign[i], 8'h77);
      if (ram_wren !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
      if (ram_wren !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL ignored_wren: got activity=%0b want 0", seen); end
    checks++; if ({cursor_y, cursor_x} !== 16'h0000) begin errors++;
      $display("FAIL ignored_cur: got %h want 0000", {cursor_y, cursor_x}); end
  endtask

`ifdef VRAM_FILL_EN
  task automatic test_fill_xy();
    int n = 0;
    int ex = 0;
    int ey = 0;
    bit bad = 1'b0;
    logic [15:0] exp_a;
    logic [15:0] bad_a = 16'd0;
    logic [15:0] bad_e = 16'd0;
    host_wr(4'd5, 8'h20);
    for (int b = 0; b < 6000; b++) begin
      tick();
      if (ram_wren === 1'b1) begin
        exp_a = 16'(ey * 256 + ex);
        if (!bad && (ram_wraddr !== exp_a || ram_data !== 8'h20)) begin
          bad = 1'b1; bad_a = ram_wraddr; bad_e = exp_a;
        end
        n++;
        ex++;
        if (ex == 80) begin ex = 0; ey++; end
      end else if (n > 0) begin
        break;
      end
    end
    checks++; if (n !== 4800) begin errors++;
      $display("FAIL fill_count: got %0d consecutive writes want 4800", n); end
    checks++; if (bad !== 1'b0) begin errors++;
      $display("FAIL fill_seq: first bad addr got %h want %h (data 20)", bad_a, bad_e); end
    checks++; if ({busy, cursor_y, cursor_x} !== 17'd0) begin errors++;
      $display("FAIL fill_end: got busy=%0b cur=%h want 0 0000", busy, {cursor_y, cursor_x}); end
  endtask

  task automatic test_fill_overflow();
    int got = 0;
    bit bad = 1'b0;
    bit extra = 1'b0;
    host_wr(4'd5, 8'h00);
    for (int i = 0; i < 9; i++) begin
      host_we = 1'b1; host_rs = 4'd1; host_data = 8'(8'h10 + i);
      tick();
    end
    host_we = 1'b0; host_rs = 4'd0; host_data = 8'd0;
    checks++; if ({fifo_full, overflow, busy} !== 3'b111) begin errors++;
      $display("FAIL ovf_set: got full=%0b ovf=%0b busy=%0b want 111", fifo_full, overflow, busy); end
    for (int b = 0; b < 6000 && got < 8; b++) begin
      tick();
      if (ram_wren === 1'b1 && ram_data !== 8'h00) begin
        if (ram_data !== 8'(16 + got) || ram_wraddr !== 16'(got)) bad = 1'b1;
        got++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      if (ram_wren === 1'b1) extra = 1'b1;
    end
    checks++; if (got !== 8 || bad !== 1'b0) begin errors++;
      $display("FAIL ovf_drain: got %0d entries order_bad=%0b want 8 in order", got, bad); end
    checks++; if ({extra, busy, overflow} !== 3'b001) begin errors++;
      $display("FAIL ovf_after: got extra=%0b busy=%0b ovf=%0b want 0 0 1", extra, busy, overflow); end
    host_wr(4'd7, 8'h00);
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL ovf_clear: got %0b want 0", overflow); end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    host_wr(4'd5, 8'h33);
    host_wr(4'd3, 8'h12);
    checks++; if (cursor_x !== 8'h12) begin errors++;
      $display("FAIL fill_curx: got %h want 12", cursor_x); end
    for (int b = 0; b < 500; b++) begin
      tick();
      if (ram_wren === 1'b1) n++;
      if (n == 100) break;
    end
    checks++; if (n !== 100) begin errors++;
      $display("FAIL midfill_count: got %0d want 100", n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({ram_wren, ram_wraddr, ram_data, busy, fifo_full, overflow, cursor_y, cursor_x} !== 44'd0) begin errors++;
      $display("FAIL midfill_rst: got wren=%0b addr=%h data=%h busy=%0b cur=%h want all 0",
               ram_wren, ram_wraddr, ram_data, busy, {cursor_y, cursor_x}); end
    host_wr(4'd1, 8'h99);
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h0000, 8'h99}) begin errors++;
      $display("FAIL post_rst_push: got wren=%0b addr=%h data=%h want 1 0000 99", ram_wren, ram_wraddr, ram_data); end
  endtask
`else
  task automatic test_fill_disabled();
    bit seen = 1'b0;
    host_wr(4'd5, 8'h20);
    for (int b = 0; b < 20; b++) begin
      if (ram_wren !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL nofill_idle: got activity=%0b want 0", seen); end
    host_wr(4'd1, 8'h5A);
    tick();
    checks++; if ({ram_wren, ram_wraddr, ram_data} !== {1'b1, 16'h0000, 8'h5A}) begin errors++;
      $display("FAIL nofill_push: got wren=%0b addr=%h data=%h want 1 0000 5a", ram_wren, ram_wraddr, ram_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_xy_push();
    test_linear();
    test_push_with_mode_change();
    test_xy_wrap();
    test_ignored_regs();
`ifdef VRAM_FILL_EN
    test_fill_xy();
    test_fill_overflow();
    test_reset_mid_fill();
`else
    test_fill_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
